global_avg_pool: RTL
====================

Name: global_avg_pool

Overview:
- Downstream consumer of the final depthwise/pointwise layer's ReLU output stream.
- Takes uint8 activations in channel-major order (all H*W pixels of ch0, then ch1, and so on).
- Accumulates each channel, emits one rounded, saturated uint8 average per channel through a valid/ready handshake, then pulses done.
- Feeds the classifier (FC) stage.

Parameters:
- IN_CH, default 32: channels per frame.
- IN_HW, default 4: feature-map height = width. Pixels per channel N = IN_HW*IN_HW.
- RECIP_Q16, default 65536/(IN_HW*IN_HW) rounded: reciprocal of N in Q0.16, localparam-derived.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that arms one frame.
- valid_in, input, 1: input pixel valid.
- ready_out, output, 1: block accepts a pixel this cycle.
- data_in, input, 8: unsigned activation.
- valid_out, output, 1: average valid.
- ready_in, input, 1: consumer accepts the average.
- data_out, output, 8: unsigned channel average.
- ch_out, output, clog2(IN_CH): channel index of data_out.
- last_out, output, 1: data_out belongs to channel IN_CH-1.
- busy, output, 1: frame in progress.
- done, output, 1: one-cycle pulse when the frame is complete.

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, accumulator and output register cleared. ready_out=0, valid_out=0, data_out=0, ch_out=0, last_out=0, busy=0, done=0.
- A pixel is accepted when valid_in && ready_out. An average is taken when valid_out && ready_in.
- States:
  - IDLE: start -> RUN; pix_cnt, ch_cnt and acc cleared.
  - RUN: accepts pixels. On acceptance of the last pixel of the last channel -> FLUSH.
  - FLUSH: ready_out=0. Once the output register is empty or draining that cycle -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in RUN and FLUSH. start outside IDLE is ignored.
- Accumulator width is 8+clog2(N) bits, which makes overflow impossible. Each accepted pixel does acc += data_in and pix_cnt += 1.
- When pix_cnt==N-1 and a pixel is accepted:
  - avg = min(255, ((acc+data_in)*RECIP_Q16 + 32768) >> 16), i.e. round-half-up.
  - The output register loads avg, ch_out=ch_cnt, last_out=(ch_cnt==IN_CH-1), valid_out=1 on the next cycle. Latency is 1 cycle from last-pixel acceptance.
  - acc<=0, pix_cnt<=0, ch_cnt<=ch_cnt+1, all in the same cycle.
- Backpressure and ready_out:
  - ready_out = (state==RUN) && !(pix_cnt==N-1 && valid_out && !ready_in).
  - Accumulation of the next channel continues while the output is held; only that channel's closing pixel stalls.
- Output register:
  - Holds data_out, ch_out and last_out stable while valid_out && !ready_in.
  - Take and load in the same cycle: the new value is loaded and valid_out stays 1.
  - Take without load: valid_out<=0.
- Non-power-of-two N is supported via RECIP_Q16. Rounding error stays within ±1 LSB of the exact rounded mean.
- Pixels presented in IDLE are not accepted (ready_out=0).
- Reset mid-frame aborts immediately. No done; partial averages are discarded.

Decomposition:
- Shared package gap_pkg:
  - function clog2
  - ACC_W = 8+clog2(IN_HW*IN_HW)
  - RECIP_Q16 derivation
  - state enum IDLE/RUN/FLUSH/DONE
- One natural sub-module: gap_out_reg, the single-entry valid/ready output skid register holding data_out, ch_out and last_out.
- Counters, accumulator and FSM stay in the top.

Test Plan:
- Constant frame (IN_CH=2, IN_HW=4): ch0 all 10, ch1 all 200, valid_in held high, ready_in=1 -> outputs (10, ch0, last=0) then (200, ch1, last=1). Each appears one cycle after its 16th pixel; done pulses 1 cycle after the second output is taken.
- Rounding: ch0 pixels sum to 24 (fifteen 1s, one 9) -> 24/16=1.5 -> data_out=2. A sum of 23 -> data_out=1.
- Saturation and range: all pixels 255 -> data_out=255. All 0 -> data_out=0.
- Backpressure: ready_in=0 from ch0's output onward. ch1 accepts its first 15 pixels, then ready_out=0 on the 16th. data_out stays 10 and stable. Raising ready_in releases ch1, with no loss or duplication.
- Handshake jitter: random valid_in/ready_in at 50% over IN_CH=32, IN_HW=4 with random pixels -> 32 averages match the reference model in order, ch_out 0..31, exactly one done.
- Reset and start: assert rst after 20 pixels -> all outputs 0 within the cycle, no done. A start during RUN is ignored. A fresh start after reset completes a clean frame.

Source files
------------

// File: rtl/gap_pkg.sv
// Shared types and elaboration-time helpers for the global average pooling block.
package gap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned Q_SHIFT = 16;
    localparam int unsigned Q_HALF  = 32768;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned v);
        return (clog2(v) == 0) ? 1 : clog2(v);
    endfunction

    function automatic int unsigned acc_w(input int unsigned hw);
        return DATA_W + clog2(hw * hw);
    endfunction

    function automatic int unsigned recip_q16(input int unsigned hw);
        return (65536 + (hw * hw) / 2) / (hw * hw);
    endfunction

endpackage

// File: rtl/global_avg_pool_if.sv
// Pixel-in / average-out handshake bundle of the global average pooling block.
interface global_avg_pool_if
    import gap_pkg::*;
#(
    parameter int unsigned IN_CH = 32
);
    localparam int unsigned CH_W = idx_w(IN_CH);

    logic              valid_in;
    logic              ready_out;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic [CH_W-1:0]   ch_out;
    logic              last_out;

    modport slave (
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out, ch_out, last_out
    );

    modport master (
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out, ch_out, last_out
    );
endinterface

// File: rtl/gap_out_reg.sv
// Single-entry valid/ready output register holding one channel average.
module gap_out_reg
    import gap_pkg::*;
#(
    parameter int unsigned CH_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CH_W-1:0]   i_ch,
    input  logic              i_last,
    input  logic              i_take,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_last
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_ch;
    logic              r_last;

    // Load wins over take so a take-and-load keeps valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ch    <= i_ch;
            r_last  <= i_last;
        end else if (r_valid && i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ch    = r_ch;
    assign o_last  = r_last;
endmodule

// File: rtl/global_avg_pool.sv
// Per-channel global average pooling of a channel-major uint8 stream, one
// rounded and saturated average per channel, then a done pulse per frame.
module global_avg_pool
    import gap_pkg::*;
#(
    parameter int unsigned IN_CH = 32,
    parameter int unsigned IN_HW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    global_avg_pool_if.slave     bus,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned N         = IN_HW * IN_HW;
    localparam int unsigned PIX_W     = idx_w(N);
    localparam int unsigned CH_W      = idx_w(IN_CH);
    localparam int unsigned ACC_W     = acc_w(IN_HW);
    localparam int unsigned RECIP_Q16 = recip_q16(IN_HW);
    localparam int unsigned PROD_W    = ACC_W + Q_SHIFT + 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [PIX_W-1:0]   r_pix_cnt;
    logic [CH_W-1:0]    r_ch_cnt;
    logic [ACC_W-1:0]   r_acc;

    logic               w_ready_c;
    logic               w_accept;
    logic               w_last_pix;
    logic               w_close;
    logic               w_last_ch;
    logic               w_ovalid;
    logic [ACC_W-1:0]   w_sum;
    logic [PROD_W-1:0]  w_prod;
    logic [PROD_W-1:0]  w_quot;
    logic [DATA_W-1:0]  w_avg;

    assign w_last_pix = (r_pix_cnt == PIX_W'(N - 1));
    assign w_last_ch  = (r_ch_cnt == CH_W'(IN_CH - 1));
    assign w_accept   = bus.valid_in && w_ready_c;
    assign w_close    = w_accept && w_last_pix;

    // Multiply by the Q0.16 reciprocal, round half up, clamp to uint8.
    assign w_sum  = r_acc + ACC_W'(bus.data_in);
    assign w_prod = PROD_W'(w_sum) * PROD_W'(RECIP_Q16) + PROD_W'(Q_HALF);
    assign w_quot = w_prod >> Q_SHIFT;
    assign w_avg  = (w_quot > PROD_W'(255)) ? 8'hFF : w_quot[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_close && w_last_ch) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (!w_ovalid || bus.ready_in) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Only a channel's closing pixel stalls while the previous average is held.
    always_comb begin
        w_ready_c = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_RUN: begin
                busy      = 1'b1;
                w_ready_c = !(w_last_pix && w_ovalid && !bus.ready_in);
            end
            ST_FLUSH: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_cnt <= '0;
            r_ch_cnt  <= '0;
            r_acc     <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_pix_cnt <= '0;
            r_ch_cnt  <= '0;
            r_acc     <= '0;
        end else if (w_accept) begin
            if (w_last_pix) begin
                r_pix_cnt <= '0;
                r_ch_cnt  <= r_ch_cnt + CH_W'(1);
                r_acc     <= '0;
            end else begin
                r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                r_acc     <= w_sum;
            end
        end
    end

    gap_out_reg #(.CH_W(CH_W)) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_close),
        .i_data  (w_avg),
        .i_ch    (r_ch_cnt),
        .i_last  (w_last_ch),
        .i_take  (bus.ready_in),
        .o_valid (w_ovalid),
        .o_data  (bus.data_out),
        .o_ch    (bus.ch_out),
        .o_last  (bus.last_out)
    );

    assign bus.ready_out = w_ready_c;
    assign bus.valid_out = w_ovalid;
endmodule
